// File: rtl/call_frame_stack.sv
// Call-frame stack: saves return PC and caller local_base per call and drives call/return pulses to the operand stack.
// Optional high-water-mark output max_depth is enabled by defining CFS_HWM_EN.
module call_frame_stack #(
    parameter int FRAME_DEPTH = 16,
    parameter int PC_WIDTH    = 32,
    parameter int SP_WIDTH    = 9
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            call_req,
    input  logic                            ret_req,
    input  logic [7:0]                      call_param_num,
    input  logic [7:0]                      call_local_num,
    input  logic [PC_WIDTH-1:0]             call_ret_pc,
    input  logic [SP_WIDTH-1:0]             top_pointer,
    output logic                            ready,
    output logic                            call,
    output logic                            return_pulse,
    output logic [7:0]                      allocate_local_memory_size,
    output logic [SP_WIDTH-1:0]             function_stack_tag,
    output logic [SP_WIDTH-1:0]             local_base,
    output logic [PC_WIDTH-1:0]             ret_pc,
    output logic                            ret_pc_valid,
    output logic [$clog2(FRAME_DEPTH):0]    frame_depth,
    output logic [2:0]                      err
`ifdef CFS_HWM_EN
    ,
    output logic [$clog2(FRAME_DEPTH):0]    max_depth
`endif
);

    localparam int AW = $clog2(FRAME_DEPTH);
    localparam int CW = (SP_WIDTH > 8) ? SP_WIDTH : 8;
    localparam int FW = PC_WIDTH + SP_WIDTH;

    typedef enum logic [1:0] {IDLE, CALL_ISSUE, RET_ISSUE} state_t;

    state_t            state, next_state;
    logic [FW-1:0]     frame_mem [FRAME_DEPTH];
    logic [FW-1:0]     rd_frame;
    logic [AW-1:0]     rd_idx;
    logic [AW:0]       depth_inc;
    logic              full, param_short;
    logic              do_call, do_ret, set_ovf, set_udf, set_puf;

    assign full        = (frame_depth == (AW+1)'(FRAME_DEPTH));
    assign param_short = (CW'(top_pointer) < CW'(call_param_num));
    assign depth_inc   = frame_depth + {{AW{1'b0}}, 1'b1};
    assign rd_idx      = frame_depth[AW-1:0] - {{(AW-1){1'b0}}, 1'b1};
    assign rd_frame    = frame_mem[rd_idx];

    assign ready        = (state == IDLE);
    assign call         = (state == CALL_ISSUE);
    assign return_pulse = (state == RET_ISSUE);
    assign ret_pc_valid = (state == RET_ISSUE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Return wins over call; both error checks on a call are evaluated independently.
    always_comb begin
        next_state = state;
        do_call    = 1'b0;
        do_ret     = 1'b0;
        set_ovf    = 1'b0;
        set_udf    = 1'b0;
        set_puf    = 1'b0;
        case (state)
            IDLE: begin
                if (ret_req) begin
                    if (frame_depth == '0) begin
                        set_udf = 1'b1;
                    end else begin
                        do_ret     = 1'b1;
                        next_state = RET_ISSUE;
                    end
                end else if (call_req) begin
                    set_ovf = full;
                    set_puf = param_short;
                    if (!full && !param_short) begin
                        do_call    = 1'b1;
                        next_state = CALL_ISSUE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_call) frame_mem[frame_depth[AW-1:0]] <= {call_ret_pc, local_base};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_depth                <= '0;
            local_base                 <= '0;
            function_stack_tag         <= '0;
            ret_pc                     <= '0;
            allocate_local_memory_size <= '0;
            err                        <= '0;
        end else begin
            if (do_call) begin
                frame_depth                <= depth_inc;
                local_base                 <= top_pointer - SP_WIDTH'(call_param_num);
                allocate_local_memory_size <= call_local_num;
            end
            if (do_ret) begin
                function_stack_tag <= local_base;
                local_base         <= rd_frame[SP_WIDTH-1:0];
                ret_pc             <= rd_frame[FW-1:SP_WIDTH];
                frame_depth        <= frame_depth - {{AW{1'b0}}, 1'b1};
            end
            err <= err | {set_puf, set_udf, set_ovf};
        end
    end

`ifdef CFS_HWM_EN
    // Depth only grows on a call, so tracking the post-call depth keeps max_depth in step with frame_depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                               max_depth <= '0;
        else if (do_call && depth_inc > max_depth) max_depth <= depth_inc;
    end
`endif

endmodule

// File: tb/tb_call_frame_stack.sv
// Randomized self-checking bench for call_frame_stack against a queue-based frame model.
module tb_call_frame_stack;

    localparam int FD  = 16;
    localparam int PCW = 32;
    localparam int SPW = 9;
    localparam int DW  = $clog2(FD);

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            call_req = 1'b0, ret_req = 1'b0;
    logic [7:0]      call_param_num = '0, call_local_num = '0;
    logic [PCW-1:0]  call_ret_pc = '0;
    logic [SPW-1:0]  top_pointer = '0;
    logic            ready, call, return_pulse, ret_pc_valid;
    logic [7:0]      allocate_local_memory_size;
    logic [SPW-1:0]  function_stack_tag, local_base;
    logic [PCW-1:0]  ret_pc;
    logic [DW:0]     frame_depth;
    logic [2:0]      err;
`ifdef CFS_HWM_EN
    logic [DW:0]     max_depth;
`endif

    call_frame_stack #(.FRAME_DEPTH(FD), .PC_WIDTH(PCW), .SP_WIDTH(SPW)) dut (
        .clk(clk), .rst_n(rst_n), .call_req(call_req), .ret_req(ret_req),
        .call_param_num(call_param_num), .call_local_num(call_local_num),
        .call_ret_pc(call_ret_pc), .top_pointer(top_pointer),
        .ready(ready), .call(call), .return_pulse(return_pulse),
        .allocate_local_memory_size(allocate_local_memory_size),
        .function_stack_tag(function_stack_tag), .local_base(local_base),
        .ret_pc(ret_pc), .ret_pc_valid(ret_pc_valid),
        .frame_depth(frame_depth), .err(err)
`ifdef CFS_HWM_EN
        , .max_depth(max_depth)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [PCW-1:0] pc;
        logic [SPW-1:0] base;
    } frame_t;

    frame_t          frames[$];
    logic [SPW-1:0]  m_base, m_tag;
    logic [PCW-1:0]  m_retpc;
    logic [2:0]      m_err;
    logic [7:0]      m_size;
    int              m_pulse;
    int              m_max;
    int              passCount = 0;
    int              checkCount = 0;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    task automatic modelReset();
        frames.delete();
        m_base = '0; m_tag = '0; m_retpc = '0; m_err = '0; m_size = '0;
        m_pulse = 0; m_max = 0;
    endtask

    task automatic checkAll();
        checkOutput("ready", 64'(ready), 64'(m_pulse == 0));
        checkOutput("call", 64'(call), 64'(m_pulse == 1));
        checkOutput("return", 64'(return_pulse), 64'(m_pulse == 2));
        checkOutput("ret_pc_valid", 64'(ret_pc_valid), 64'(m_pulse == 2));
        if (m_pulse == 1) checkOutput("alloc_size", 64'(allocate_local_memory_size), 64'(m_size));
        checkOutput("stack_tag", 64'(function_stack_tag), 64'(m_tag));
        checkOutput("ret_pc", 64'(ret_pc), 64'(m_retpc));
        checkOutput("local_base", 64'(local_base), 64'(m_base));
        checkOutput("frame_depth", 64'(frame_depth), 64'(frames.size()));
        checkOutput("err", 64'(err), 64'(m_err));
`ifdef CFS_HWM_EN
        checkOutput("max_depth", 64'(max_depth), 64'(m_max));
`endif
    endtask

    // Drives one cycle of requests at the falling edge, advances the model, then checks at the next falling edge.
    task automatic applyStimulus(input logic cr, input logic rr, input logic [7:0] pn, input logic [7:0] ln,
                                 input logic [PCW-1:0] pc, input logic [SPW-1:0] tp);
        frame_t f;
        bit bad;
        call_req = cr; ret_req = rr; call_param_num = pn; call_local_num = ln;
        call_ret_pc = pc; top_pointer = tp;
        if (m_pulse != 0) begin
            m_pulse = 0;
        end else if (rr) begin
            if (frames.size() == 0) m_err[1] = 1'b1;
            else begin
                f = frames.pop_back();
                m_tag = m_base; m_base = f.base; m_retpc = f.pc; m_pulse = 2;
            end
        end else if (cr) begin
            bad = 0;
            if (frames.size() == FD) begin m_err[0] = 1'b1; bad = 1; end
            if (int'(tp) < int'(pn)) begin m_err[2] = 1'b1; bad = 1; end
            if (!bad) begin
                f.pc = pc; f.base = m_base;
                frames.push_back(f);
                m_base = SPW'(int'(tp) - int'(pn));
                m_size = ln; m_pulse = 1;
                if (frames.size() > m_max) m_max = frames.size();
            end
        end
        @(posedge clk);
        @(negedge clk);
        checkAll();
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 8'd0, 8'd0, '0, '0);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0;
        call_req = 1'b0; ret_req = 1'b0;
        #2;
        modelReset();
        checkAll();
        checkOutput("reset_alloc_size", 64'(allocate_local_memory_size), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        modelReset();
        doReset();

        // Basic call then return with known values.
        applyStimulus(1'b1, 1'b0, 8'd2, 8'd3, 32'h40, 9'd5);
        checkOutput("d_call_size", 64'(allocate_local_memory_size), 64'd3);
        checkOutput("d_call_base", 64'(local_base), 64'd3);
        idleCycle();
        applyStimulus(1'b0, 1'b1, 8'd0, 8'd0, '0, 9'd0);
        checkOutput("d_ret_tag", 64'(function_stack_tag), 64'd3);
        checkOutput("d_ret_pc", 64'(ret_pc), 64'h40);
        idleCycle();
        idleCycle();

        // Simultaneous call and return at depth 1: return wins.
        applyStimulus(1'b1, 1'b0, 8'd1, 8'd4, 32'h100, 9'd20);
        idleCycle();
        applyStimulus(1'b1, 1'b1, 8'd1, 8'd4, 32'h200, 9'd30);
        checkOutput("d_both_call", 64'(call), 64'd0);
        idleCycle();

        // Underflow cases.
        doReset();
        applyStimulus(1'b0, 1'b1, 8'd0, 8'd0, '0, 9'd0);
        checkOutput("d_frame_udf", 64'(err), 64'b010);
        doReset();
        applyStimulus(1'b1, 1'b0, 8'd2, 8'd1, 32'h8, 9'd1);
        checkOutput("d_param_udf", 64'(err[2]), 64'd1);

        // Overflow after FD nested calls.
        doReset();
        for (int i = 0; i < FD + 1; i++) begin
            applyStimulus(1'b1, 1'b0, 8'd0, 8'(i), 32'(i * 4), 9'(i));
            idleCycle();
        end
        checkOutput("d_ovf_err", 64'(err), 64'b001);
        checkOutput("d_ovf_depth", 64'(frame_depth), 64'(FD));
        for (int i = 0; i < FD; i++) begin
            applyStimulus(1'b0, 1'b1, 8'd0, 8'd0, '0, '0);
            idleCycle();
        end

        // Reset while a call pulse is in flight.
        doReset();
        applyStimulus(1'b1, 1'b0, 8'd1, 8'd2, 32'h44, 9'd9);
        rst_n = 1'b0;
        #1;
        modelReset();
        checkAll();
        @(negedge clk);
        rst_n = 1'b1;
        idleCycle();

        // Randomized traffic.
        doReset();
        for (int n = 0; n < 600; n++) begin
            logic [7:0] pn;
            pn = ($urandom_range(0, 19) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 7));
            applyStimulus(1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 9) < 3), pn,
                          8'($urandom), $urandom, 9'($urandom));
            if ($urandom_range(0, 199) == 0) doReset();
        end

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/call_frame_stack.md
CALL_FRAME_STACK -- requirements
Module: call_frame_stack

Interface
REQ-001 Parameter FRAME_DEPTH, 16, maximum number of nested call frames; power of two, 2 to 256.
REQ-002 Parameter PC_WIDTH, 32, width of the saved return program counter.
REQ-003 Parameter SP_WIDTH, 9, operand-stack pointer width; matches the operand stack's top-pointer width.
REQ-004 Clocking and reset: one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 call_req  input  1  request to enter a function; qualified by ready.
REQ-008 ret_req  input  1  request to leave the current function; qualified by ready.
REQ-009 call_param_num  input  8  argument count already on the operand stack.
REQ-010 call_local_num  input  8  count of non-argument locals to allocate.
REQ-011 call_ret_pc  input  PC_WIDTH  return address saved with the frame.
REQ-012 top_pointer  input  SP_WIDTH  current operand-stack top pointer.
REQ-013 ready  output  1  block idle and able to accept a request.
REQ-014 call  output  1  one-cycle pulse to the operand stack: allocate locals.
REQ-015 return  output  1  one-cycle pulse to the operand stack: restore top.
REQ-016 allocate_local_memory_size  output  8  local allocation count, valid while call=1.
REQ-017 function_stack_tag  output  SP_WIDTH  restored top pointer, valid while return=1.
REQ-018 local_base  output  SP_WIDTH  operand-stack index of local 0 of the current frame.
REQ-019 ret_pc  output  PC_WIDTH  popped return address, valid while ret_pc_valid=1.
REQ-020 ret_pc_valid  output  1  one-cycle strobe accompanying return.
REQ-021 frame_depth  output  log2(FRAME_DEPTH)+1  number of live frames.
REQ-022 err  output  3  sticky flags {param_underflow, frame_underflow, frame_overflow}.

Function
REQ-023 The FSM SHALL have states IDLE, CALL_ISSUE, and RET_ISSUE, with ready=1 only in IDLE.
REQ-024 In IDLE with ret_req=1, the block SHALL service the return and ignore call_req (return has priority).
REQ-025 Accepted call with frame_depth==FRAME_DEPTH: set err[0], no write, no pulse, stay IDLE.
REQ-026 Accepted call with top_pointer<call_param_num: set err[2], no write, no pulse, stay IDLE.
REQ-027 Valid accepted call SHALL, in that edge:
- write {call_ret_pc, local_base} to frame[frame_depth];
- increment frame_depth;
- set local_base to top_pointer-call_param_num;
- latch call_local_num;
- go to CALL_ISSUE.
REQ-028 In CALL_ISSUE: call=1 and allocate_local_memory_size=latched count for exactly one cycle, then IDLE; the call pulse is seen one cycle after acceptance.
REQ-029 Accepted return with frame_depth==0: set err[1], no pulse, stay IDLE.
REQ-030 Valid accepted return SHALL, in that edge:
- set function_stack_tag to the current local_base;
- restore local_base and ret_pc from frame[frame_depth-1];
- decrement frame_depth;
- go to RET_ISSUE.
REQ-031 In RET_ISSUE: return=1 and ret_pc_valid=1 for exactly one cycle, then IDLE.
REQ-032 Requests asserted outside IDLE SHALL be ignored and not queued.
REQ-033 call and return SHALL never be high in the same cycle.
REQ-034 function_stack_tag and ret_pc SHALL hold their value until the next valid return.

Reset
REQ-035 While rst_n=0, the block SHALL hold:
- state IDLE, ready=1;
- call=0, return=0, ret_pc_valid=0;
- allocate_local_memory_size=0, function_stack_tag=0, local_base=0;
- ret_pc=0, frame_depth=0, err=0.
REQ-036 Reset asserted mid-CALL_ISSUE or mid-RET_ISSUE SHALL abort without a pulse; frame memory contents are don't-care.

Configuration
REQ-037 With macro CFS_HWM_EN defined, the block SHALL add an output max_depth (same width as frame_depth), reset 0, updated to frame_depth whenever frame_depth exceeds it.
REQ-038 Without CFS_HWM_EN, the max_depth port and its register SHALL not exist, with all other behaviour identical.

Verification
REQ-039 Valid call: top_pointer=5, param=2, local=3, pc=0x40 -> next cycle call=1, size=3; local_base=3; frame_depth=1.
REQ-040 Return after REQ-039 -> next cycle return=1, function_stack_tag=3, ret_pc=0x40; local_base=0; frame_depth=0.
REQ-041 Frame overflow: FRAME_DEPTH=16, 17 calls -> 17th gives err=3'b001, no call pulse; frame_depth stays 16.
REQ-042 Frame underflow and param underflow:
- return at depth 0 -> err=3'b010, no return pulse;
- call with top_pointer=1, param=2 -> err[2]=1.
REQ-043 call_req=ret_req=1 at depth 1 -> only the return pulse occurs.
REQ-044 Reset mid-flight: rst_n low during CALL_ISSUE -> no call pulse, all outputs at reset values; with CFS_HWM_EN, max_depth=0.
